// File: rtl/switch_allocator.sv
// Separable input-first switch allocator: per-input round-robin VC pick, per-output matrix arbiter.
// Build option SWALLOC_PKT_LOCK_EN holds an output for a whole packet, from head to tail.
module switch_allocator #(
   parameter int unsigned NUM_PORTS = 5,
   parameter int unsigned NUM_VCS   = 4,
   localparam int unsigned OPW      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_PORTS*NUM_VCS-1:0]     req,
   input  logic [NUM_PORTS*NUM_VCS*OPW-1:0] req_outport,
   input  logic [NUM_PORTS*NUM_VCS-1:0]     req_tail,
   input  logic [NUM_PORTS*NUM_VCS-1:0]     credit_ok,
   output logic [NUM_PORTS*NUM_VCS-1:0]     grant_vc,
   output logic [NUM_PORTS-1:0]             xbar_valid,
   output logic [NUM_PORTS*OPW-1:0]         xbar_sel
);

   localparam int unsigned VCW = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
   localparam int          NP  = int'(NUM_PORTS);
   localparam int          NV  = int'(NUM_VCS);

   // Priority state: per-input RR pointer, per-output matrix w_q[out][i][j] (i beats j when set)
   logic [VCW-1:0]       ptr_q [NUM_PORTS];
   logic [VCW-1:0]       ptr_d [NUM_PORTS];
   logic [NUM_PORTS-1:0] w_q   [NUM_PORTS][NUM_PORTS];
   logic [NUM_PORTS-1:0] w_d   [NUM_PORTS][NUM_PORTS];

   // Packet lock per output: owner input and VC
   logic [NUM_PORTS-1:0] lock_valid;
   logic [OPW-1:0]       lock_in [NUM_PORTS];
   logic [VCW-1:0]       lock_vc [NUM_PORTS];

   logic [NUM_VCS-1:0]   elig [NUM_PORTS];
   logic [NUM_PORTS-1:0] s1_valid;
   logic [VCW-1:0]       s1_vc  [NUM_PORTS];
   logic [OPW-1:0]       s1_out [NUM_PORTS];
   logic [NUM_PORTS-1:0] s2_req [NUM_PORTS];
   logic [NUM_PORTS-1:0] s2_gnt [NUM_PORTS];
   logic [NUM_PORTS-1:0] in_gnt;

   always_comb begin
      for (int p = 0; p < NP; p++) begin
         for (int v = 0; v < NV; v++) begin
            elig[p][v] = req[p*NV+v] & credit_ok[p*NV+v]
                       & (32'(req_outport[(p*NV+v)*OPW +: OPW]) < NUM_PORTS);
            for (int o = 0; o < NP; o++) begin
               if (lock_valid[o] && (req_outport[(p*NV+v)*OPW +: OPW] == OPW'(o))
                   && ((lock_in[o] != OPW'(p)) || (lock_vc[o] != VCW'(v)))) begin
                  elig[p][v] = 1'b0;
               end
            end
         end
      end
   end

   // Stage 1: descending scan so the eligible VC closest to the pointer is the last one written
   always_comb begin
      for (int p = 0; p < NP; p++) begin
         s1_valid[p] = 1'b0;
         s1_vc[p]    = '0;
         for (int k = NV - 1; k >= 0; k--) begin
            if (elig[p][(int'(ptr_q[p]) + k) % NV]) begin
               s1_valid[p] = 1'b1;
               s1_vc[p]    = VCW'((int'(ptr_q[p]) + k) % NV);
            end
         end
         for (int o = NP - 1; o >= 0; o--) begin
            if (lock_valid[o] && (lock_in[o] == OPW'(p)) && elig[p][lock_vc[o]]) begin
               s1_valid[p] = 1'b1;
               s1_vc[p]    = lock_vc[o];
            end
         end
         s1_out[p] = req_outport[(p*NV + int'(s1_vc[p]))*OPW +: OPW];
      end
   end

   // Stage 2: weights are antisymmetric, so exactly one requester survives per output
   always_comb begin
      for (int o = 0; o < NP; o++) begin
         for (int p = 0; p < NP; p++) begin
            s2_req[o][p] = s1_valid[p] && (s1_out[p] == OPW'(o))
                           && (!lock_valid[o] || (lock_in[o] == OPW'(p)));
         end
      end
      for (int o = 0; o < NP; o++) begin
         for (int i = 0; i < NP; i++) begin
            s2_gnt[o][i] = s2_req[o][i];
            for (int j = 0; j < NP; j++) begin
               if (s2_req[o][j] && w_q[o][j][i]) begin
                  s2_gnt[o][i] = 1'b0;
               end
            end
         end
      end
   end

   always_comb begin
      in_gnt     = '0;
      grant_vc   = '0;
      xbar_valid = '0;
      xbar_sel   = '0;
      for (int o = 0; o < NP; o++) begin
         for (int p = 0; p < NP; p++) begin
            if (s2_gnt[o][p]) begin
               in_gnt[p]                = 1'b1;
               xbar_valid[o]            = 1'b1;
               xbar_sel[o*OPW +: OPW]   = OPW'(p);
            end
         end
      end
      for (int p = 0; p < NP; p++) begin
         if (in_gnt[p]) begin
            grant_vc[p*NV + int'(s1_vc[p])] = 1'b1;
         end
      end
      if (!reset) begin
         grant_vc   = '0;
         xbar_valid = '0;
         xbar_sel   = '0;
      end
   end

   // Continuation flits on a locked output leave the priority state alone
   always_comb begin
      ptr_d = ptr_q;
      w_d   = w_q;
      for (int o = 0; o < NP; o++) begin
         for (int p = 0; p < NP; p++) begin
            if (s2_gnt[o][p] && !lock_valid[o]) begin
               ptr_d[p] = VCW'((int'(s1_vc[p]) + 1) % NV);
               for (int j = 0; j < NP; j++) begin
                  if (j != p) begin
                     w_d[o][p][j] = 1'b0;
                     w_d[o][j][p] = 1'b1;
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int p = 0; p < NP; p++) begin
            ptr_q[p] <= '0;
         end
         for (int o = 0; o < NP; o++) begin
            for (int i = 0; i < NP; i++) begin
               for (int j = 0; j < NP; j++) begin
                  w_q[o][i][j] <= (i < j);
               end
            end
         end
      end else begin
         ptr_q <= ptr_d;
         w_q   <= w_d;
      end
   end

`ifdef SWALLOC_PKT_LOCK_EN
   logic [NUM_PORTS-1:0] lock_valid_d;
   logic [OPW-1:0]       lock_in_d [NUM_PORTS];
   logic [VCW-1:0]       lock_vc_d [NUM_PORTS];

   // A non-tail grant (re)arms the lock; a tail grant, including head+tail, leaves it clear
   always_comb begin
      lock_valid_d = lock_valid;
      lock_in_d    = lock_in;
      lock_vc_d    = lock_vc;
      for (int o = 0; o < NP; o++) begin
         for (int p = 0; p < NP; p++) begin
            if (s2_gnt[o][p]) begin
               lock_valid_d[o] = ~req_tail[p*NV + int'(s1_vc[p])];
               lock_in_d[o]    = OPW'(p);
               lock_vc_d[o]    = s1_vc[p];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lock_valid <= '0;
         for (int o = 0; o < NP; o++) begin
            lock_in[o] <= '0;
            lock_vc[o] <= '0;
         end
      end else begin
         lock_valid <= lock_valid_d;
         lock_in    <= lock_in_d;
         lock_vc    <= lock_vc_d;
      end
   end
`else
   logic unused_tail;

   assign lock_valid  = '0;
   assign unused_tail = ^req_tail;

   always_comb begin
      for (int o = 0; o < NP; o++) begin
         lock_in[o] = '0;
         lock_vc[o] = '0;
      end
   end
`endif

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: reset, VC round-robin, credit and range gating,
// output matrix priority, packet lock (when SWALLOC_PKT_LOCK_EN is defined) and async reset.
module tb_switch_allocator;

   localparam int NP  = 5;
   localparam int NV  = 4;
   localparam int OPW = 3;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NP*NV-1:0]     req;
   logic [NP*NV*OPW-1:0] req_outport;
   logic [NP*NV-1:0]     req_tail;
   logic [NP*NV-1:0]     credit_ok;
   logic [NP*NV-1:0]     grant_vc;
   logic [NP-1:0]        xbar_valid;
   logic [NP*OPW-1:0]    xbar_sel;

   int total = 0;
   int bad   = 0;

   logic [31:0] rr_exp [4];

   switch_allocator #(
      .NUM_PORTS (NP),
      .NUM_VCS   (NV)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .req_outport (req_outport),
      .req_tail    (req_tail),
      .credit_ok   (credit_ok),
      .grant_vc    (grant_vc),
      .xbar_valid  (xbar_valid),
      .xbar_sel    (xbar_sel)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      req         = '0;
      req_outport = '0;
      req_tail    = '1;
      credit_ok   = '0;
   endtask

   task automatic add(input int p, input int v, input int o, input logic tail, input logic cr);
      req[p*NV+v]                    = 1'b1;
      req_outport[(p*NV+v)*OPW +: OPW] = OPW'(o);
      req_tail[p*NV+v]               = tail;
      credit_ok[p*NV+v]              = cr;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      clr();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      tick();
   endtask

   initial begin
      // Outputs forced low while reset is held, even with a live request
      reset = 1'b0;
      clr();
      add(0, 0, 2, 1'b1, 1'b1);
      settle();
      check("rst_grant", 32'(grant_vc), 32'h0);
      check("rst_valid", 32'(xbar_valid), 32'h0);
      check("rst_sel", 32'(xbar_sel), 32'h0);
      do_reset();

      // Reset priority on out2: in0 first, then in1
      clr();
      add(0, 0, 2, 1'b1, 1'b1);
      add(1, 0, 2, 1'b1, 1'b1);
      settle();
      check("prio0_grant", 32'(grant_vc), 32'h1);
      check("prio0_valid", 32'(xbar_valid), 32'h4);
      check("prio0_sel", 32'(xbar_sel), 32'h0);
      tick();
      settle();
      check("prio1_grant", 32'(grant_vc), 32'h10);
      check("prio1_sel", 32'(xbar_sel), 32'h40);
      tick();

      // Input round-robin across in0 VC0..2 to distinct outputs
      do_reset();
      clr();
      add(0, 0, 0, 1'b1, 1'b1);
      add(0, 1, 1, 1'b1, 1'b1);
      add(0, 2, 2, 1'b1, 1'b1);
      rr_exp = '{32'h1, 32'h2, 32'h4, 32'h1};
      for (int k = 0; k < 4; k++) begin
         settle();
         check($sformatf("rr%0d_grant", k), 32'(grant_vc), rr_exp[k]);
         check($sformatf("rr%0d_valid", k), 32'(xbar_valid), rr_exp[k]);
         tick();
      end

      // Credit gating: no credit, then credit raised within the same cycle
      clr();
      add(3, 1, 0, 1'b1, 1'b0);
      settle();
      check("cred0_grant", 32'(grant_vc), 32'h0);
      check("cred0_valid", 32'(xbar_valid), 32'h0);
      credit_ok[3*NV+1] = 1'b1;
      #1;
      check("cred1_grant", 32'(grant_vc), 32'h2000);
      check("cred1_valid", 32'(xbar_valid), 32'h1);
      check("cred1_sel", 32'(xbar_sel), 32'h3);
      tick();

      // Out-of-range outports are never granted and do not move the in2 pointer
      clr();
      add(2, 0, 5, 1'b1, 1'b1);
      add(2, 1, 7, 1'b1, 1'b1);
      settle();
      check("oor_grant", 32'(grant_vc), 32'h0);
      check("oor_valid", 32'(xbar_valid), 32'h0);
      tick();
      clr();
      add(2, 0, 1, 1'b1, 1'b1);
      add(2, 1, 3, 1'b1, 1'b1);
      settle();
      check("oor_after_grant", 32'(grant_vc), 32'h100);
      check("oor_after_valid", 32'(xbar_valid), 32'h2);
      check("oor_after_sel", 32'(xbar_sel), 32'h10);
      tick();

      // Packet on out4 from in1 VC2 contending with in0 VC0
      do_reset();
      clr();
      add(0, 0, 4, 1'b1, 1'b1);
      settle();
      check("pkt_pre_grant", 32'(grant_vc), 32'h1);
      tick();
      add(1, 2, 4, 1'b0, 1'b1);
      settle();
      check("pkt_f1_grant", 32'(grant_vc), 32'h40);
      check("pkt_f1_sel", 32'(xbar_sel), 32'h1000);
      tick();
      credit_ok[1*NV+2] = 1'b0;
      settle();
`ifdef SWALLOC_PKT_LOCK_EN
      check("pkt_bub_grant", 32'(grant_vc), 32'h0);
      check("pkt_bub_valid", 32'(xbar_valid), 32'h0);
`else
      check("pkt_bub_grant", 32'(grant_vc), 32'h1);
      check("pkt_bub_valid", 32'(xbar_valid), 32'h10);
`endif
      tick();
      credit_ok[1*NV+2] = 1'b1;
      settle();
      check("pkt_f2_grant", 32'(grant_vc), 32'h40);
      check("pkt_f2_sel", 32'(xbar_sel), 32'h1000);
      tick();
      req_tail[1*NV+2] = 1'b1;
      settle();
`ifdef SWALLOC_PKT_LOCK_EN
      check("pkt_f3_grant", 32'(grant_vc), 32'h40);
`else
      check("pkt_f3_grant", 32'(grant_vc), 32'h1);
`endif
      tick();
      settle();
`ifdef SWALLOC_PKT_LOCK_EN
      check("pkt_post_grant", 32'(grant_vc), 32'h1);
      check("pkt_post_sel", 32'(xbar_sel), 32'h0);
`else
      check("pkt_post_grant", 32'(grant_vc), 32'h40);
      check("pkt_post_sel", 32'(xbar_sel), 32'h1000);
`endif
      tick();

      // Asynchronous reset between flit 1 and flit 2 of an in1 packet
      do_reset();
      clr();
      add(0, 0, 4, 1'b1, 1'b1);
      settle();
      tick();
      add(1, 2, 4, 1'b0, 1'b1);
      settle();
      check("ar_f1_grant", 32'(grant_vc), 32'h40);
      tick();
      #2;
      reset = 1'b0;
      #1;
      check("ar_grant", 32'(grant_vc), 32'h0);
      check("ar_valid", 32'(xbar_valid), 32'h0);
      check("ar_sel", 32'(xbar_sel), 32'h0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("ar_rel_grant", 32'(grant_vc), 32'h1);
      check("ar_rel_valid", 32'(xbar_valid), 32'h10);
      check("ar_rel_sel", 32'(xbar_sel), 32'h0);
      tick();
      settle();
      check("ar_next_grant", 32'(grant_vc), 32'h40);
      check("ar_next_sel", 32'(xbar_sel), 32'h1000);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
- Separable input-first switch allocator for the virtual-channel router.
- Each cycle, every input port picks one requesting VC using round-robin.
- Each output port then picks one input using a matrix arbiter (least-recently-served).
- Drives crossbar selects and per-VC grants. Optionally holds an output for a whole packet (head to tail).

Parameters:
- NUM_PORTS, 5, number of router input ports and output ports.
- NUM_VCS, 4, virtual channels per input port.
- OPW, $clog2(NUM_PORTS), width of an output-port index (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  NUM_PORTS*NUM_VCS  VC has a flit ready. Index is p*NUM_VCS+v.
- req_outport  input  NUM_PORTS*NUM_VCS*OPW  requested output per VC. Field for index i is [i*OPW +: OPW].
- req_tail  input  NUM_PORTS*NUM_VCS  requesting flit is a tail; single-flit packets assert it too.
- credit_ok  input  NUM_PORTS*NUM_VCS  downstream VC has at least one credit.
- grant_vc  output  NUM_PORTS*NUM_VCS  VC wins this cycle; at most one bit per input port.
- xbar_valid  output  NUM_PORTS  output port is driven this cycle.
- xbar_sel  output  NUM_PORTS*OPW  winning input index for each output; 0 when xbar_valid=0.

Behaviour:
- Grants are combinational from the current req/credit and the registered priority state. Latency is 0 cycles; priority and lock state update at the next rising edge.
- Reset asserted (reset=0):
  - grant_vc, xbar_valid and xbar_sel are forced to 0.
  - Input RR pointers are set to 0.
  - Matrix weights w[i][j]=1 for i<j, so lower index has higher priority.
  - All output locks are cleared.
  - Deassertion takes effect at the next edge.
- Eligibility: a VC is eligible iff req=1 AND credit_ok=1 AND req_outport<NUM_PORTS AND the target output is not locked to a different (input,vc). An out-of-range outport is never granted.
- Stage 1, per input:
  - Round-robin over eligible VCs, starting at the pointer.
  - If this input owns a lock on some output and the lock-owner VC is eligible, that VC is chosen regardless of the pointer.
- Stage 2, per output:
  - Matrix arbiter over inputs whose stage-1 winner targets this output.
  - Winner i has no j with w[j][i]=1 that is also requesting.
  - If the output is locked, only the owner input can win. The output idles while the owner is ineligible (no credit or no req); this is not a deadlock.
- Grant: grant_vc[p*NUM_VCS+v]=1 only if the VC wins both stages. A stage-1 winner that loses stage 2 gets no grant, and no other VC of that input is tried this cycle.
- Priority update at edge, only for granted inputs and outputs:
  - Input RR pointer moves to (v+1) mod NUM_VCS.
  - Matrix: winner i gets w[i][j]=0 and w[j][i]=1 for all j≠i.
  - When the feature is compiled in, the matrix and pointer are not updated for non-head continuation grants on a locked output.
- Simultaneous events: one input may win several outputs only through different VCs in different cycles; never two grants per input per cycle. Two inputs targeting the same output resolve by matrix only.

Optional Feature:
- Macro SWALLOC_PKT_LOCK_EN.
- Defined:
  - A grant with req_tail=0 locks that output to (input,vc) at the edge.
  - A grant with req_tail=1 from the owner clears the lock at the edge.
  - A head+tail single-flit grant never locks.
  - Reset clears all locks.
- Undefined:
  - No lock state; every flit is arbitrated independently.
  - Flits from different packets may interleave on an output.
  - The "locked to a different owner" eligibility term is constant 0.

Test Plan:
- Reset priority: after reset release, in0 VC0 and in1 VC0 both request out2 with credit → grant_vc[0]=1, xbar_sel[out2]=0. Next cycle with the same requests → in1 wins (xbar_sel=1).
- Input round-robin: in0 VCs 0,1,2 all request distinct outputs for 4 cycles → grant_vc[0..3] sequence 0001, 0010, 0100, 0001.
- Credit gating: in3 VC1 requests out0 with credit_ok=0 → no grant, xbar_valid[0]=0. Raise credit_ok → grant the same cycle.
- Out-of-range: req_outport=5 or 7 with NUM_PORTS=5 → no grant, state unchanged.
- Lock (SWALLOC_PKT_LOCK_EN):
  - in1 VC2 sends a 3-flit packet (tail on the 3rd) to out4 while in0 VC0 also requests out4 → in1 wins 3 consecutive cycles, then in0 wins.
  - A credit_ok=0 bubble mid-packet leaves out4 idle, not granted to in0.
- Async reset mid-packet: assert reset between flits 1 and 2 → outputs 0 immediately. After release, in0 wins out4 by index priority and the lock is gone.
